// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage
//
// Owns the program counter and issues pipelined word requests to instruction
// memory. Up to FIFO_DEPTH requests may be in flight; their PCs ride along in
// a small pc queue so each in-order response can be paired with the address
// that produced it. Responses are buffered in a FIFO_DEPTH-entry FIFO and
// drained into the IF/ID pipeline register. A response that arrives while
// the FIFO is empty and IF/ID is free goes straight into IF/ID.
//
// A redirect from decode (branch_taken with stall[2] low) moves the PC,
// flushes the FIFO, bubbles IF/ID and marks every still-outstanding request
// for discard, so stale responses are dropped as they return.
//
// Build option:
//   IF_MISALIGN_CHECK_EN  When defined, adds output fetch_misaligned. A redirect
//                         to a non word-aligned target sets it (sticky until
//                         rst) and fetching stops; IF/ID drains the FIFO and
//                         then emits bubbles. When undefined, the low two bits
//                         of branch_addr are ignored.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   synchronous active-high reset
//   stall[5:0]        in   [0] hold PC / no new requests, [1] hold IF/ID,
//                          [2] decode held (redirect ignored); [5:3] unused here
//   branch_taken      in   redirect request from decode
//   branch_addr[31:0] in   redirect target
//   imem_req          out  request valid (combinational from state)
//   imem_addr[31:0]   out  request word address (current pc)
//   imem_gnt          in   request accepted this cycle
//   imem_rvalid       in   response valid, in order, >=1 cycle after gnt
//   imem_rdata[31:0]  in   response instruction
//   id_pc[31:0]       out  IF/ID: pc of id_inst
//   id_inst[31:0]     out  IF/ID: instruction (NOP_INST when bubbled)
//   id_valid          out  IF/ID holds a real fetched instruction
//   fetch_misaligned  out  (IF_MISALIGN_CHECK_EN only) sticky misaligned flag
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
`ifdef IF_MISALIGN_CHECK_EN
    output logic        id_valid,
    output logic        fetch_misaligned
`else
    output logic        id_valid
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Occupancy (outstanding + buffered) is compared one bit wider so the sum
    // can never wrap.
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [31:0]   pq_mem [FIFO_DEPTH];
    logic [AW-1:0] pq_wr;
    logic [AW-1:0] pq_rd;

    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [CW-1:0] fifo_count;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic          redirect;
    logic [31:0]   target;
    logic          fetch_stop;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          resp;
    logic          resp_keep;
    logic          fifo_empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding_nxt;
    logic          unused_ok;

    assign redirect = branch_taken && !stall[2];

`ifdef IF_MISALIGN_CHECK_EN
    logic misaligned;

    assign target           = branch_addr;
    assign fetch_stop       = misaligned;
    assign fetch_misaligned = misaligned;
    assign unused_ok        = ^stall[5:3];
`else
    assign target     = {branch_addr[31:2], 2'b00};
    assign fetch_stop = 1'b0;
    assign unused_ok  = ^{stall[5:3], branch_addr[1:0]};
`endif

    // Every request in flight already owns a buffer slot, so responses can
    // always be accepted and the FIFO never overflows.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};

    // No new request in the redirect cycle: pc is about to change, and the
    // first request to the target goes out on the following cycle.
    assign imem_req  = !rst && !stall[0] && (occupancy < DEPTH_LIM)
                       && !redirect && !fetch_stop;
    assign imem_addr = pc;
    assign issue     = imem_req && imem_gnt;

    // A beat with nothing outstanding belongs to a request lost across a
    // reset; it is ignored entirely.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign resp_keep = resp && (discard == '0);
    assign resp_pc   = pq_mem[pq_rd];

    assign fifo_empty = (fifo_count == '0);
    assign bypass     = resp_keep && fifo_empty && !stall[1] && !redirect;
    assign push       = resp_keep && !bypass && !redirect;
    assign pop        = !fifo_empty && !stall[1] && !redirect;

    // NOTE: every variable assigned in an always_comb gets a default on the
    // first line so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        outstanding_nxt = outstanding;
        if (issue && !resp) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (!issue && resp) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // PC and request/response bookkeeping
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
        end else begin
            outstanding <= outstanding_nxt;

            if (redirect) begin
                pc <= target;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            // Whatever is still in flight after this cycle's updates belongs
            // to the abandoned path; a gnt in this cycle is included.
            if (redirect) begin
                discard <= outstanding_nxt;
            end else if (resp && (discard != '0)) begin
                discard <= discard - 1'b1;
            end

            if (issue) begin
                pq_wr <= pq_wr + 1'b1;
            end
            if (resp) begin
                pq_rd <= pq_rd + 1'b1;
            end
        end
    end

    // NOTE: queue and FIFO storage is not reset; the pointers and counters
    // decide which entries are meaningful, so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            pq_mem[pq_wr] <= pc;
        end
        if (push) begin
            fifo_pc[fifo_wr]   <= resp_pc;
            fifo_inst[fifo_wr] <= imem_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFO pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_wr <= fifo_wr + 1'b1;
            end
            if (pop) begin
                fifo_rd <= fifo_rd + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (redirect) begin
            // Bubble overrides an IF/ID hold; id_pc keeps its last value.
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!stall[1]) begin
            if (!fifo_empty) begin
                id_pc    <= fifo_pc[fifo_rd];
                id_inst  <= fifo_inst[fifo_rd];
                id_valid <= 1'b1;
            end else if (bypass) begin
                id_pc    <= resp_pc;
                id_inst  <= imem_rdata;
                id_valid <= 1'b1;
            end else begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // -------------------------------------------------------------------------
    // Sticky misaligned-redirect flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (redirect && (branch_addr[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed bench for if_fetch
//
// The instruction memory is a simple in-order queue: a granted address is
// queued at the clock edge and presented back (rdata = addr | 0x13) while
// resp_en is high, one beat per cycle. gnt and resp_en are steered by the
// directed steps below. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef IF_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .id_pc            (id_pc),
        .id_inst          (id_inst),
`ifdef IF_MISALIGN_CHECK_EN
        .id_valid         (id_valid),
        .fetch_misaligned (fetch_misaligned)
`else
        .id_valid         (id_valid)
`endif
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- memory
    logic        resp_en = 1'b1;
    logic [31:0] mq_mem [16];
    logic [3:0]  mq_wr = '0;
    logic [3:0]  mq_rd = '0;

    assign imem_rvalid = resp_en && (mq_wr != mq_rd);
    assign imem_rdata  = mq_mem[mq_rd] | 32'h0000_0013;

    always @(posedge clk) begin
        if (rst) begin
            mq_wr <= '0;
            mq_rd <= '0;
        end else begin
            if (imem_rvalid) mq_rd <= mq_rd + 4'd1;
            if (imem_req && imem_gnt) begin
                mq_mem[mq_wr] <= imem_addr;
                mq_wr         <= mq_wr + 4'd1;
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Two reset edges, check reset state, release; returns in the first
    // cycle out of reset with rst already low.
    task automatic do_reset();
        rst          = 1'b1;
        branch_taken = 1'b0;
        stall        = '0;
        step();
        step();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0000_0000);
        check("rst_id_pc", id_pc, 32'h0000_0000);
        check("rst_inst",  id_inst, 32'h0000_0013);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
`ifdef IF_MISALIGN_CHECK_EN
        check("rst_misal", {31'd0, fetch_misaligned}, 32'd0);
`endif
        rst = 1'b0;
        settle();
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        // 1) Streaming fetch: gnt always, one-cycle responses.
        imem_gnt = 1'b1;
        resp_en  = 1'b1;
        do_reset();
        check("s_req0",   {31'd0, imem_req}, 32'd1);
        check("s_addr0",  imem_addr, 32'h0);
        check("s_valid0", {31'd0, id_valid}, 32'd0);
        step();
        check("s_addr1",  imem_addr, 32'h4);
        check("s_valid1", {31'd0, id_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s_id_pc",   id_pc, 32'(4 * k));
            check("s_id_inst", id_inst, 32'(4 * k) | 32'h13);
            check("s_valid",   {31'd0, id_valid}, 32'd1);
            check("s_addr",    imem_addr, 32'(4 * k + 8));
        end

        // 2) No grant for five cycles: pc parked, request held, bubbles.
        imem_gnt = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            check("g_req",   {31'd0, imem_req}, 32'd1);
            check("g_addr",  imem_addr, 32'h0);
            check("g_valid", {31'd0, id_valid}, 32'd0);
            check("g_inst",  id_inst, 32'h0000_0013);
            step();
        end
        check("g_addr_end", imem_addr, 32'h0);

        // 3) Redirect with requests 8 and 12 outstanding.
        imem_gnt = 1'b1;
        resp_en  = 1'b1;
        do_reset();
        step();
        step();
        step();
        resp_en = 1'b0;
        settle();
        check("r_id_pc4", id_pc, 32'h4);
        check("r_req12",  {31'd0, imem_req}, 32'd1);
        check("r_addr12", imem_addr, 32'hC);
        step();
        check("r_full",   {31'd0, imem_req}, 32'd0);
        check("r_bub0",   {31'd0, id_valid}, 32'd0);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0100;
        settle();
        check("r_req_br", {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        resp_en      = 1'b1;
        settle();
        check("r_addr_t", imem_addr, 32'h100);
        check("r_req_dr", {31'd0, imem_req}, 32'd0);
        check("r_bub1",   {31'd0, id_valid}, 32'd0);
        check("r_inst1",  id_inst, 32'h0000_0013);
        step();
        check("r_req_t",  {31'd0, imem_req}, 32'd1);
        check("r_addr_t2", imem_addr, 32'h100);
        check("r_bub2",   {31'd0, id_valid}, 32'd0);
        step();
        check("r_bub3",   {31'd0, id_valid}, 32'd0);
        check("r_addr_n", imem_addr, 32'h104);
        step();
        check("r_id_pc",  id_pc, 32'h100);
        check("r_id_inst", id_inst, 32'h113);
        check("r_valid",  {31'd0, id_valid}, 32'd1);

        // 4) IF/ID hold with FIFO filling up.
        imem_gnt = 1'b1;
        resp_en  = 1'b1;
        do_reset();
        step();
        step();
        check("h_id_pc0", id_pc, 32'h0);
        stall = 6'b000010;
        settle();
        check("h_req8",   {31'd0, imem_req}, 32'd1);
        check("h_addr8",  imem_addr, 32'h8);
        for (int k = 0; k < 3; k++) begin
            step();
            check("h_req",   {31'd0, imem_req}, 32'd0);
            check("h_id_pc", id_pc, 32'h0);
            check("h_inst",  id_inst, 32'h13);
            check("h_valid", {31'd0, id_valid}, 32'd1);
        end
        stall = '0;
        step();
        check("h_pc4",    id_pc, 32'h4);
        check("h_inst4",  id_inst, 32'h17);
        check("h_req12",  {31'd0, imem_req}, 32'd1);
        check("h_addr12", imem_addr, 32'hC);
        step();
        check("h_pc8",    id_pc, 32'h8);
        check("h_inst8",  id_inst, 32'h1B);
        step();
        check("h_pc12",   id_pc, 32'hC);
        check("h_inst12", id_inst, 32'h1F);
        check("h_valid12", {31'd0, id_valid}, 32'd1);

        // 5) Redirect blocked by stall[2], then taken.
        imem_gnt = 1'b0;
        do_reset();
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0040;
        stall        = 6'b000100;
        settle();
        check("b_req_st", {31'd0, imem_req}, 32'd1);
        step();
        check("b_addr_st", imem_addr, 32'h0);
        stall = '0;
        settle();
        check("b_req_rd", {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        settle();
        check("b_addr_tk", imem_addr, 32'h40);
        check("b_req_tk", {31'd0, imem_req}, 32'd1);

        // 6) PC wrap at the top of the address space.
        imem_gnt = 1'b0;
        do_reset();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        imem_gnt     = 1'b1;
        resp_en      = 1'b0;
        settle();
        check("w_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("w_req_top", {31'd0, imem_req}, 32'd1);
        step();
        check("w_addr_wrap", imem_addr, 32'h0);

        // 7) Redirect to an unaligned target.
        imem_gnt = 1'b0;
        resp_en  = 1'b1;
        do_reset();
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0102;
        step();
        branch_taken = 1'b0;
        settle();
`ifdef IF_MISALIGN_CHECK_EN
        check("m_flag", {31'd0, fetch_misaligned}, 32'd1);
        check("m_req0", {31'd0, imem_req}, 32'd0);
        imem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("m_req",   {31'd0, imem_req}, 32'd0);
            check("m_valid", {31'd0, id_valid}, 32'd0);
            check("m_flag_s", {31'd0, fetch_misaligned}, 32'd1);
        end
        rst = 1'b1;
        step();
        check("m_flag_rst", {31'd0, fetch_misaligned}, 32'd0);
        rst = 1'b0;
        settle();
        check("m_req_rst", {31'd0, imem_req}, 32'd1);
`else
        check("m_addr_al", imem_addr, 32'h100);
        check("m_req_al",  {31'd0, imem_req}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
